// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : des_pkg
//  Description : Shared DES types, permutation tables and helper functions
//                used by the key schedule, the round stack and the IP/FP
//                blocks. All tables use DES 1-based bit numbering, where
//                bit 1 is the MSB of the vector being permuted.
//  Revision    : 1.0 - initial release
// ============================================================================
package des_pkg;

    typedef logic [47:0] round_key_t;
    typedef logic [27:0] half_key_t;

    localparam int DES_ROUNDS = 16;

    // Permuted choice 1: 64-bit key -> 56-bit C||D, parity bits dropped
    localparam int unsigned PC1_TAB [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // Permuted choice 2: 56-bit C||D -> 48-bit round subkey
    localparam int unsigned PC2_TAB [0:47] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left-rotation amount applied to C and D before each round's PC2
    localparam int unsigned SHIFTS [0:15] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    // Key-schedule controller states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GEN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // PC1: output bit j (1-based) takes key bit PC1_TAB[j-1] (1-based)
    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] res;
        res = '0;
        for (int j = 0; j < 56; j++) begin
            res[55-j] = key[64-PC1_TAB[j]];
        end
        return res;
    endfunction

    // 28-bit left rotation by one or two positions
    function automatic half_key_t rotl(input half_key_t h, input int unsigned amt);
        return (amt == 2) ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_key_schedule_if.sv
`default_nettype none
// ============================================================================
//  Module      : des_key_schedule_if
//  Description : Key-load handshake and subkey-bank bus between a key source
//                (master) and the DES key schedule (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface des_key_schedule_if;
    import des_pkg::*;

    logic        key_valid_i;
    logic        key_ready_o;
    logic [63:0] key_i;
    logic        decrypt_i;
    round_key_t  round_keys_o [0:DES_ROUNDS-1];
    logic        keys_valid_o;

    // Key source side: offers keys, observes the finished bank
    modport master (
        output key_valid_i,
        output key_i,
        output decrypt_i,
        input  key_ready_o,
        input  round_keys_o,
        input  keys_valid_o
    );

    // Key schedule side
    modport slave (
        input  key_valid_i,
        input  key_i,
        input  decrypt_i,
        output key_ready_o,
        output round_keys_o,
        output keys_valid_o
    );

endinterface
`default_nettype wire

// File: rtl/des_pc2.sv
`default_nettype none
// ============================================================================
//  Module      : des_pc2
//  Description : Combinational DES permuted choice 2 (56 -> 48 bits).
//                Pure wiring; bit 1 is the MSB of both vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd_i,
    output round_key_t  key_o
);

    // Each subkey bit is a fixed tap into C||D
    for (genvar j = 0; j < 48; j++) begin : g_pc2
        assign key_o[47-j] = cd_i[56-PC2_TAB[j]];
    end

endmodule
`default_nettype wire

// File: rtl/des_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : des_key_schedule
//  Description : Sequential DES key schedule. Accepts one 64-bit key, then
//                derives one 48-bit subkey per clock over 16 cycles into a
//                registered bank. In decrypt mode the bank is filled in
//                reverse so the downstream round stack is reused as-is.
//  Revision    : 1.0 - initial release
// ============================================================================
module des_key_schedule
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    des_key_schedule_if.slave  kif
);

    localparam logic [3:0] LAST_CNT = 4'(NUM_ROUNDS - 1);

    logic [1:0] state_q;
    logic [1:0] state_d;
    half_key_t  c_q;
    half_key_t  d_q;
    half_key_t  c_d;
    half_key_t  d_d;
    logic [3:0] cnt_q;
    logic       dec_q;
    logic       valid_q;
    round_key_t bank_q [0:DES_ROUNDS-1];

    logic       key_ready;
    logic       accept;
    logic [3:0] idx;
    round_key_t subkey;

    assign accept = kif.key_valid_i & key_ready;

    // Controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a key starts generation, the 16th subkey ends it
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE,
            ST_DONE: if (kif.key_valid_i) state_d = ST_GEN;
            ST_GEN:  if (cnt_q == LAST_CNT) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller outputs: keys are refused only while generating
    always_comb begin
        key_ready = (state_q != ST_GEN);
    end

    // Rotated halves for this round and the bank slot they land in
    always_comb begin
        c_d = rotl(c_q, SHIFTS[cnt_q]);
        d_d = rotl(d_q, SHIFTS[cnt_q]);
        idx = dec_q ? (LAST_CNT - cnt_q) : cnt_q;
    end

    des_pc2 u_pc2 (
        .cd_i  ({c_d, d_d}),
        .key_o (subkey)
    );

    // Datapath: load C/D on accept, then rotate and write one subkey per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            valid_q <= 1'b0;
            for (int i = 0; i < DES_ROUNDS; i++) begin
                bank_q[i] <= '0;
            end
        end else if (accept) begin
            {c_q, d_q} <= pc1(kif.key_i);
            dec_q      <= kif.decrypt_i;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
        end else if (state_q == ST_GEN) begin
            c_q         <= c_d;
            d_q         <= d_d;
            bank_q[idx] <= subkey;
            cnt_q       <= cnt_q + 4'd1;
            if (cnt_q == LAST_CNT) begin
                valid_q <= 1'b1;
            end
        end
    end

    assign kif.key_ready_o  = key_ready;
    assign kif.keys_valid_o = valid_q;

    for (genvar g = 0; g < DES_ROUNDS; g++) begin : g_bank_out
        assign kif.round_keys_o[g] = bank_q[g];
    end

`ifndef SYNTHESIS
    // The shifts sum to 28, so a finished schedule leaves C/D at their PC1
    // value; 16 samples back is the cycle right after the accept.
    a_cd_wraps : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_GEN && cnt_q == LAST_CNT)
        |=> ({c_q, d_q} == $past({c_q, d_q}, 16)));
`endif

endmodule
`default_nettype wire

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Sequential DES key-schedule generator. It sits directly upstream of the 16-round combinational stack and produces the round_keys[0:15] bank that the stack consumes.
- Accepts one 64-bit key per transaction and derives one 48-bit subkey per clock over 16 cycles.
- Holds all 16 subkeys stable in a register bank with a valid flag.
- For decryption the bank is written in reverse order, so the round stack is reused unchanged.

Parameters:
- NUM_ROUNDS, 16, number of subkeys generated; fixed at 16 for DES, and the parameter exists for bench readability only.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  asynchronous active-low reset
- key_valid_i  input  1  a key is offered on key_i
- key_ready_o  output  1  block can accept a key this cycle
- key_i  input  64  DES key; bit 63 = DES bit 1; parity bits (DES bits 8,16,..,64) ignored
- decrypt_i  input  1  sampled with key; 1 = store subkeys in reverse order
- round_keys_o  output  48 x [0:15]  subkey bank; entry i feeds round i of the stack
- keys_valid_o  output  1  bank holds a complete schedule for the last accepted key

Behaviour:
- Reset (async assert, sync deassert handled by top): state=IDLE, all 16 bank entries=0, C/D=0, counter=0, keys_valid_o=0, key_ready_o=1.
- Accept: a key is accepted on a rising edge where key_valid_i & key_ready_o.
- key_ready_o = 1 in IDLE and DONE, 0 in GEN.
- On accept:
  - C||D (28+28) <= PC1(key_i).
  - dec_r <= decrypt_i.
  - cnt <= 0.
  - keys_valid_o <= 0.
  - state <= GEN.
- GEN, each cycle with cnt = n (0..15):
  - C', D' = left-rotate C, D by SHIFTS[n], where SHIFTS = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - C <= C', D <= D'.
  - bank[idx] <= PC2(C'||D'), where idx = dec_r ? 15-n : n.
  - cnt <= n+1.
- GEN exit: on the edge writing n=15, state <= DONE and keys_valid_o <= 1.
- Latency: keys_valid_o rises exactly 17 edges after the accept edge (accept edge + 16 GEN edges); 16 cycles of key_ready_o=0.
- DONE:
  - Bank and keys_valid_o are held until the next accept.
  - A new accept in DONE drops keys_valid_o the following cycle. Bank entries keep their old values until individually overwritten.
  - Consumers must only use round_keys_o while keys_valid_o=1.
- key_valid_i during GEN is ignored (not accepted, not queued). decrypt_i is only sampled at accept.
- Total shift after 16 rounds is 28, so C/D return to their PC1 value. This is a required invariant and is checked by assertion in DONE.
- Reset mid-GEN:
  - Everything clears immediately to reset values.
  - No partial schedule is flagged valid.
  - The next key starts from cnt=0.
- The output bank is registered only; no combinational path from key_i to round_keys_o.

Decomposition:
- des_pkg holds:
  - typedef round_key_t (logic [47:0]) and half_key_t (logic [27:0]).
  - PC1 table (56 entries) and PC2 table (48 entries) as constant arrays using DES 1-based bit numbering.
  - SHIFTS[0:15] constant.
  - DES_ROUNDS = 16.
- The shared package is reused by the round stack and the future initial/final permutation blocks.
- One sub-module, des_pc2: purely combinational 56->48 permutation, instantiated once inside des_key_schedule.
- PC1 is inlined via a package function.
- The state machine, counter and bank stay in the top.

Test Plan:
- Reset, then idle 5 cycles -> keys_valid_o=0, key_ready_o=1, all bank entries 0.
- Encrypt key 0x133457799BBCDFF1, decrypt_i=0 -> keys_valid_o high 17 edges later, with:
  - round_keys_o[0]=0x1B02EFFC7072
  - round_keys_o[15]=0xCB3D8B0E17F5
  - key_ready_o low for exactly 16 cycles.
- Same key, decrypt_i=1 -> round_keys_o[0]=0xCB3D8B0E17F5, round_keys_o[15]=0x1B02EFFC7072, entries 1..14 are the reverse of the encrypt run.
- Parity-bit independence: key 0x123456789ABCDEF0 vs the same key with every byte's LSB toggled -> identical banks.
- Pulse key_valid_i with a different key during GEN -> ignored; final bank matches the first key only.
- Assert rst_n=0 at GEN cycle 7, release, load 0x133457799BBCDFF1 -> keys_valid_o stays 0 until the fresh run completes, then the bank matches the encrypt vector. Then load a second key in DONE -> keys_valid_o drops the next cycle and rises 17 edges after that accept.
